// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage feeding a SIPO, LSB first, with a 1-entry holding buffer.
// Latency: first bit on s_out one cycle after accept; back-to-back words have no idle bit.
// Backpressure: in_ready = !buf_full (registered); en=0 freezes the serial stream only.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] p_in,
  input  logic             p_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] buf_q;
  logic             buf_full;

  logic accept;
  logic at_last;
  logic advance;
  logic word_end;
  logic load_buf;
  logic load_in;
  logic to_buf;

  // The buffer can only be refilled while it is empty, so in_ready never
  // depends on p_valid.
  assign in_ready = !buf_full;
  assign accept   = p_valid && in_ready;

  assign at_last  = (state == SHIFT) && (cnt == LAST_CNT);
  assign advance  = (state == SHIFT) && en;
  assign word_end = advance && at_last;

  // A freeing shifter takes the buffered word first, else a bypassed new word.
  // An idle shifter loads a new word even when en is low.
  assign load_buf = word_end && buf_full;
  assign load_in  = accept && ((state == IDLE) || (word_end && !buf_full));
  assign to_buf   = accept && !load_in;

  assign s_valid = (state == SHIFT);
  assign s_out   = s_valid && shift_q[0];
  assign s_last  = at_last;
  assign busy    = s_valid || buf_full;

  // Shifter and bit counter: load, advance on en, or drop to idle after the last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shift_q <= '0;
      cnt     <= '0;
    end else if (load_buf) begin
      state   <= SHIFT;
      shift_q <= buf_q;
      cnt     <= '0;
    end else if (load_in) begin
      state   <= SHIFT;
      shift_q <= p_in;
      cnt     <= '0;
    end else if (word_end) begin
      state   <= IDLE;
      shift_q <= '0;
      cnt     <= '0;
    end else if (advance) begin
      shift_q <= shift_q >> 1;
      cnt     <= cnt + 1'b1;
    end
  end

  // Holding buffer: captures a word while the shifter is occupied, drains on word end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
    end else if (load_buf) begin
      buf_full <= 1'b0;
    end else if (to_buf) begin
      buf_q    <= p_in;
      buf_full <= 1'b1;
    end
  end

endmodule
